// File: rtl/eth_rx_axi_burst_reader.sv
// AXI4 read-channel front end for the Ethernet RX path: burst reads of status
// registers and of the FWFT RX FIFO data window, with frame-boundary padding.
module eth_rx_axi_burst_reader #(
  parameter int              DATA_W   = 32,
  parameter int              ADDR_W   = 16,
  parameter int              COUNT_W  = 16,
  parameter logic [ADDR_W-1:0] A_STATUS = 'h0000,
  parameter logic [ADDR_W-1:0] A_COUNT  = 'h0004,
  parameter logic [ADDR_W-1:0] A_PROTO  = 'h0008,
  parameter logic [ADDR_W-1:0] A_FRAMES = 'h000C,
  parameter logic [ADDR_W-1:0] A_DATA   = 'h0010
) (
  input  logic               clk_100_mhz,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  s_araddr,
  input  logic [7:0]         s_arlen,
  input  logic               s_arvalid,
  output logic               s_arready,
  output logic [DATA_W-1:0]  s_rdata,
  output logic [1:0]         s_rresp,
  output logic               s_rlast,
  output logic               s_rvalid,
  input  logic               s_rready,
  input  logic               rx_ready,
  input  logic [COUNT_W-1:0] rx_byte_count,
  input  logic [15:0]        rx_protocol_type,
  input  logic [DATA_W-1:0]  rx_data,
  output logic               rx_read_en,
  output logic               rx_clear
);
  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = $clog2(BYTES);

  typedef enum logic [1:0] {IDLE = 2'd0, BURST = 2'd1, CLEAR = 2'd2} state_t;
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [8:0]        beats_left;
  } ar_req_t;

  state_t           state, state_nx;
  ar_req_t          req;
  logic             frame_active, frame_done;
  logic [COUNT_W:0] remaining, frame_words;
  logic [31:0]      frames;
  logic             beat_ok, ar_hs, r_hs, is_data, pop, last_word, frame_start, mapped;
  logic [DATA_W-1:0] rd_val;

  // Words in the frame, rounded up to whole bus beats.
  assign frame_words = ({1'b0, rx_byte_count} + (COUNT_W+1)'(BYTES-1)) >> SHIFT;
  assign beat_ok     = (state == BURST) && !rst;
  assign ar_hs       = (state == IDLE) && !rst && s_arvalid;
  assign r_hs        = beat_ok && s_rready;
  assign is_data     = (req.addr == A_DATA);
  assign pop         = r_hs && is_data && frame_active && (remaining != '0);
  assign last_word   = pop && (remaining == (COUNT_W+1)'(1));
  assign frame_start = ar_hs && (s_araddr == A_DATA) && !frame_active && rx_ready;

  always_ff @(posedge clk_100_mhz) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk_100_mhz) begin
    if (rst) begin
      req          <= '0;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      remaining    <= '0;
      frames       <= '0;
    end else begin
      if (ar_hs) begin
        req.addr       <= s_araddr;
        req.beats_left <= {1'b0, s_arlen} + 9'd1;
      end
      // A zero-length frame is finished the moment it is picked up.
      if (frame_start) begin
        if (rx_byte_count == '0) begin
          frame_done <= 1'b1;
        end else begin
          frame_active <= 1'b1;
          remaining    <= frame_words;
        end
      end
      if (r_hs) req.beats_left <= req.beats_left - 9'd1;
      if (pop) remaining <= remaining - (COUNT_W+1)'(1);
      if (last_word) begin
        frame_active <= 1'b0;
        frame_done   <= 1'b1;
      end
      if (state == CLEAR) begin
        frame_done <= 1'b0;
        frames     <= frames + 32'd1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (ar_hs) state_nx = BURST;
      BURST:   if (r_hs && req.beats_left == 9'd1)
                 state_nx = (frame_done || last_word) ? CLEAR : IDLE;
      CLEAR:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Beat payload is combinational so FIFO data follows the FWFT head with no bubble.
  always_comb begin
    rd_val = '0;
    mapped = 1'b1;
    case (req.addr)
      A_STATUS: rd_val[1:0] = {frame_active, rx_ready};
      A_COUNT:  rd_val[COUNT_W-1:0] = rx_byte_count;
      A_PROTO:  rd_val[15:0] = rx_protocol_type;
      A_FRAMES: rd_val[31:0] = frames;
      A_DATA:   if (frame_active && remaining != '0) rd_val = rx_data;
      default:  mapped = 1'b0;
    endcase
  end

  always_comb begin
    s_arready  = 1'b0;
    s_rvalid   = 1'b0;
    s_rlast    = 1'b0;
    s_rresp    = 2'b00;
    s_rdata    = '0;
    rx_read_en = 1'b0;
    rx_clear   = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:  s_arready = 1'b1;
        BURST: begin
          s_rvalid   = beat_ok;
          s_rlast    = (req.beats_left == 9'd1);
          s_rresp    = mapped ? 2'b00 : 2'b10;
          s_rdata    = rd_val;
          rx_read_en = pop;
        end
        CLEAR: rx_clear = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_eth_rx_axi_burst_reader.sv
// Directed bench for eth_rx_axi_burst_reader: a 32-bit and a 64-bit instance share
// the AR/R stimulus; per-instance FWFT FIFO models feed rx_data.
module tb_eth_rx_axi_burst_reader;
  logic        clk_100_mhz = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] s_araddr = '0;
  logic [7:0]  s_arlen = '0;
  logic        s_arvalid = 1'b0;
  logic        s_rready = 1'b0;
  logic [15:0] rx_protocol_type = 16'h0800;

  logic        rx_ready32 = 1'b0, rx_ready64 = 1'b0;
  logic [15:0] count32 = '0, count64 = '0;
  logic [31:0] rx_data32, rdata32;
  logic [63:0] rx_data64, rdata64;
  logic        arready32, rvalid32, rlast32, rd_en32, clear32;
  logic        arready64, rvalid64, rlast64, rd_en64, clear64;
  logic [1:0]  rresp32, rresp64;

  logic [31:0] mem32 [0:15];
  logic [63:0] mem64 [0:15];
  logic [3:0]  cnt32 = '0, cnt64 = '0, base32 = '0, base64 = '0;
  logic [3:0]  idx32, idx64;
  assign idx32 = cnt32 - base32;
  assign idx64 = cnt64 - base64;
  assign rx_data32 = mem32[idx32];
  assign rx_data64 = mem64[idx64];
  always @(posedge clk_100_mhz) begin
    if (rd_en32) cnt32 <= cnt32 + 4'd1;
    if (rd_en64) cnt64 <= cnt64 + 4'd1;
  end

  logic        sel64 = 1'b0;
  logic        obs_arready, obs_rvalid, obs_rlast, obs_read_en, obs_clear;
  logic [1:0]  obs_rresp;
  logic [63:0] obs_rdata;
  assign obs_arready = sel64 ? arready64 : arready32;
  assign obs_rvalid  = sel64 ? rvalid64  : rvalid32;
  assign obs_rlast   = sel64 ? rlast64   : rlast32;
  assign obs_read_en = sel64 ? rd_en64   : rd_en32;
  assign obs_clear   = sel64 ? clear64   : clear32;
  assign obs_rresp   = sel64 ? rresp64   : rresp32;
  assign obs_rdata   = sel64 ? rdata64   : {32'h0, rdata32};

  eth_rx_axi_burst_reader #(.DATA_W(32)) u_dut (
    .clk_100_mhz(clk_100_mhz), .rst(rst), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arvalid(s_arvalid), .s_arready(arready32), .s_rdata(rdata32), .s_rresp(rresp32),
    .s_rlast(rlast32), .s_rvalid(rvalid32), .s_rready(s_rready), .rx_ready(rx_ready32),
    .rx_byte_count(count32), .rx_protocol_type(rx_protocol_type), .rx_data(rx_data32),
    .rx_read_en(rd_en32), .rx_clear(clear32));

  eth_rx_axi_burst_reader #(.DATA_W(64)) u_dut64 (
    .clk_100_mhz(clk_100_mhz), .rst(rst), .s_araddr(s_araddr), .s_arlen(s_arlen),
    .s_arvalid(s_arvalid), .s_arready(arready64), .s_rdata(rdata64), .s_rresp(rresp64),
    .s_rlast(rlast64), .s_rvalid(rvalid64), .s_rready(s_rready), .rx_ready(rx_ready64),
    .rx_byte_count(count64), .rx_protocol_type(rx_protocol_type), .rx_data(rx_data64),
    .rx_read_en(rd_en64), .rx_clear(clear64));

  always #5 clk_100_mhz = ~clk_100_mhz;

  localparam logic [15:0] A_STATUS = 16'h0000, A_COUNT = 16'h0004, A_PROTO = 16'h0008;
  localparam logic [15:0] A_FRAMES = 16'h000C, A_DATA = 16'h0010;

  int n_cmp = 0, n_bad = 0;

  // Results captured by run_burst.
  int          nb, pops, clears, first_cyc, last_cyc;
  logic        to, stall_bad;
  logic [63:0] b_data [0:15];
  logic [1:0]  b_resp [0:15];
  logic [15:0] b_last;

  task automatic load32(input logic [15:0] cnt, input logic [31:0] seed);
    for (int i = 0; i < 16; i++) mem32[i] = seed + i;
    base32 = cnt32;
    count32 = cnt;
  endtask

  task automatic load64(input logic [15:0] cnt, input logic [63:0] seed);
    for (int i = 0; i < 16; i++) mem64[i] = seed + 64'(i);
    base64 = cnt64;
    count64 = cnt;
  endtask

  // Issue one AR and record every R beat; rr[c] is s_rready in burst cycle c.
  task automatic run_burst(input logic [15:0] addr, input logic [7:0] len, input logic [31:0] rr);
    int cyc, tail;
    logic stalled, sl;
    logic [63:0] sd;
    logic [1:0] sr;
    nb = 0; pops = 0; clears = 0; first_cyc = -1; last_cyc = -1;
    to = 1'b0; stall_bad = 1'b0; b_last = '0; stalled = 1'b0;
    sd = '0; sr = '0; sl = 1'b0;
    @(negedge clk_100_mhz);
    s_araddr = addr; s_arlen = len; s_arvalid = 1'b1; s_rready = 1'b0;
    #1;
    if (obs_arready !== 1'b1) to = 1'b1;
    @(negedge clk_100_mhz);
    s_arvalid = 1'b0;
    cyc = 0; tail = -1;
    while (cyc < 64 && (tail < 0 || cyc < tail)) begin
      s_rready = (cyc < 32) ? rr[cyc] : 1'b1;
      #1;
      if (stalled && (obs_rdata !== sd || obs_rresp !== sr || obs_rlast !== sl)) stall_bad = 1'b1;
      stalled = obs_rvalid && !s_rready;
      sd = obs_rdata; sr = obs_rresp; sl = obs_rlast;
      if (obs_read_en) pops++;
      if (obs_clear) clears++;
      if (obs_rvalid && s_rready) begin
        if (nb < 16) begin
          b_data[nb] = obs_rdata; b_resp[nb] = obs_rresp; b_last[nb] = obs_rlast;
        end
        if (first_cyc < 0) first_cyc = cyc;
        last_cyc = cyc;
        nb++;
        if (obs_rlast && tail < 0) tail = cyc + 3;
      end
      @(negedge clk_100_mhz);
      cyc++;
    end
    s_rready = 1'b0;
    if (tail < 0) to = 1'b1;
  endtask

  task automatic test_reset;
    @(negedge clk_100_mhz); #1;
    n_cmp++; if (obs_arready !== 1'b0) begin n_bad++; $display("FAIL reset_arready got=%b exp=0", obs_arready); end
    n_cmp++; if ({obs_rvalid, obs_rlast, obs_rresp} !== 4'b0) begin n_bad++; $display("FAIL reset_r got=%b exp=0000", {obs_rvalid, obs_rlast, obs_rresp}); end
    n_cmp++; if (obs_rdata !== 64'h0) begin n_bad++; $display("FAIL reset_rdata got=%h exp=0", obs_rdata); end
    n_cmp++; if ({obs_read_en, obs_clear} !== 2'b00) begin n_bad++; $display("FAIL reset_fifo got=%b exp=00", {obs_read_en, obs_clear}); end
    @(negedge clk_100_mhz); rst = 1'b0; #1;
    n_cmp++; if (obs_arready !== 1'b1) begin n_bad++; $display("FAIL idle_arready got=%b exp=1", obs_arready); end
    run_burst(A_FRAMES, 8'd0, '1);
    n_cmp++; if (b_data[0] !== 64'h0) begin n_bad++; $display("FAIL reset_frames got=%h exp=0", b_data[0]); end
  endtask

  task automatic test_single_frame;
    load32(16'd10, 32'h1111_0000); rx_ready32 = 1'b1;
    run_burst(A_DATA, 8'd3, '1);
    rx_ready32 = 1'b0;
    n_cmp++; if (to !== 1'b0 || nb !== 4) begin n_bad++; $display("FAIL t1_beats got=%0d to=%b exp=4", nb, to); end
    n_cmp++; if (b_data[0] !== 64'h1111_0000 || b_data[1] !== 64'h1111_0001) begin n_bad++; $display("FAIL t1_data01 got=%h %h exp=11110000 11110001", b_data[0], b_data[1]); end
    n_cmp++; if (b_data[2] !== 64'h1111_0002 || b_data[3] !== 64'h0) begin n_bad++; $display("FAIL t1_data23 got=%h %h exp=11110002 0", b_data[2], b_data[3]); end
    n_cmp++; if (b_last[3:0] !== 4'b1000) begin n_bad++; $display("FAIL t1_rlast got=%b exp=1000", b_last[3:0]); end
    n_cmp++; if (pops !== 3 || clears !== 1) begin n_bad++; $display("FAIL t1_pop_clear got=%0d/%0d exp=3/1", pops, clears); end
    n_cmp++; if (first_cyc !== 0 || last_cyc !== 3) begin n_bad++; $display("FAIL t1_timing got=%0d..%0d exp=0..3", first_cyc, last_cyc); end
    run_burst(A_FRAMES, 8'd0, '1);
    n_cmp++; if (b_data[0] !== 64'd1 || b_resp[0] !== 2'b00) begin n_bad++; $display("FAIL t1_frames got=%h/%b exp=1/00", b_data[0], b_resp[0]); end
  endtask

  task automatic test_multi_burst;
    load32(16'd24, 32'h2222_0000); rx_ready32 = 1'b1;
    run_burst(A_DATA, 8'd2, '1);
    rx_ready32 = 1'b0;
    n_cmp++; if (nb !== 3 || b_data[0] !== 64'h2222_0000 || b_data[2] !== 64'h2222_0002) begin n_bad++; $display("FAIL t2_burst1 got=%0d %h %h exp=3 22220000 22220002", nb, b_data[0], b_data[2]); end
    n_cmp++; if (pops !== 3 || clears !== 0) begin n_bad++; $display("FAIL t2_pop_clear1 got=%0d/%0d exp=3/0", pops, clears); end
    run_burst(A_STATUS, 8'd0, '1);
    n_cmp++; if (b_data[0] !== 64'h2) begin n_bad++; $display("FAIL t2_status got=%h exp=2", b_data[0]); end
    run_burst(A_DATA, 8'd2, '1);
    n_cmp++; if (nb !== 3 || b_data[0] !== 64'h2222_0003 || b_data[1] !== 64'h2222_0004 || b_data[2] !== 64'h2222_0005) begin n_bad++; $display("FAIL t2_burst2 got=%0d %h %h %h exp=3 22220003..5", nb, b_data[0], b_data[1], b_data[2]); end
    n_cmp++; if (pops !== 3 || clears !== 1) begin n_bad++; $display("FAIL t2_pop_clear2 got=%0d/%0d exp=3/1", pops, clears); end
    run_burst(A_FRAMES, 8'd0, '1);
    n_cmp++; if (b_data[0] !== 64'd2) begin n_bad++; $display("FAIL t2_frames got=%h exp=2", b_data[0]); end
  endtask

  task automatic test_backpressure;
    load32(16'd16, 32'h3333_0000); rx_ready32 = 1'b1;
    run_burst(A_DATA, 8'd3, 32'hFFFF_FFF9);
    rx_ready32 = 1'b0;
    n_cmp++; if (nb !== 4 || b_data[0] !== 64'h3333_0000 || b_data[1] !== 64'h3333_0001 || b_data[2] !== 64'h3333_0002 || b_data[3] !== 64'h3333_0003) begin n_bad++; $display("FAIL t3_data got=%0d %h %h %h %h exp=4 33330000..3", nb, b_data[0], b_data[1], b_data[2], b_data[3]); end
    n_cmp++; if (stall_bad !== 1'b0) begin n_bad++; $display("FAIL t3_stall_stable got=%b exp=0", stall_bad); end
    n_cmp++; if (pops !== 4 || clears !== 1) begin n_bad++; $display("FAIL t3_pop_clear got=%0d/%0d exp=4/1", pops, clears); end
    n_cmp++; if (first_cyc !== 0 || last_cyc !== 5 || b_last[3:0] !== 4'b1000) begin n_bad++; $display("FAIL t3_timing got=%0d..%0d last=%b exp=0..5 1000", first_cyc, last_cyc, b_last[3:0]); end
  endtask

  task automatic test_unmapped;
    run_burst(16'h0020, 8'd1, '1);
    n_cmp++; if (nb !== 2 || b_data[0] !== 64'h0 || b_data[1] !== 64'h0) begin n_bad++; $display("FAIL t4_data got=%0d %h %h exp=2 0 0", nb, b_data[0], b_data[1]); end
    n_cmp++; if (b_resp[0] !== 2'b10 || b_resp[1] !== 2'b10) begin n_bad++; $display("FAIL t4_resp got=%b %b exp=10 10", b_resp[0], b_resp[1]); end
    n_cmp++; if (b_last[1:0] !== 2'b10 || pops !== 0 || clears !== 0) begin n_bad++; $display("FAIL t4_last_pop got=%b %0d %0d exp=10 0 0", b_last[1:0], pops, clears); end
  endtask

  task automatic test_zero_len;
    load32(16'd0, 32'h4444_0000); rx_ready32 = 1'b1;
    run_burst(A_DATA, 8'd1, '1);
    rx_ready32 = 1'b0;
    n_cmp++; if (nb !== 2 || b_data[0] !== 64'h0 || b_data[1] !== 64'h0 || b_resp[0] !== 2'b00) begin n_bad++; $display("FAIL zero_data got=%0d %h %h %b exp=2 0 0 00", nb, b_data[0], b_data[1], b_resp[0]); end
    n_cmp++; if (pops !== 0 || clears !== 1) begin n_bad++; $display("FAIL zero_pop_clear got=%0d/%0d exp=0/1", pops, clears); end
    run_burst(A_FRAMES, 8'd0, '1);
    n_cmp++; if (b_data[0] !== 64'd4) begin n_bad++; $display("FAIL zero_frames got=%h exp=4", b_data[0]); end
  endtask

  task automatic test_width64;
    sel64 = 1'b1;
    load64(16'd9, 64'hC0DE_0000_0000_0000); rx_ready64 = 1'b1;
    run_burst(A_COUNT, 8'd0, '1);
    n_cmp++; if (b_data[0] !== 64'd9) begin n_bad++; $display("FAIL t5_count got=%h exp=9", b_data[0]); end
    run_burst(A_PROTO, 8'd0, '1);
    n_cmp++; if (b_data[0] !== 64'h0800) begin n_bad++; $display("FAIL t5_proto got=%h exp=0800", b_data[0]); end
    run_burst(A_DATA, 8'd2, '1);
    rx_ready64 = 1'b0;
    n_cmp++; if (nb !== 3 || b_data[0] !== 64'hC0DE_0000_0000_0000 || b_data[1] !== 64'hC0DE_0000_0000_0001 || b_data[2] !== 64'h0) begin n_bad++; $display("FAIL t5_data got=%0d %h %h %h exp=3 c0de..0 c0de..1 0", nb, b_data[0], b_data[1], b_data[2]); end
    n_cmp++; if (pops !== 2 || clears !== 1) begin n_bad++; $display("FAIL t5_pop_clear got=%0d/%0d exp=2/1", pops, clears); end
    sel64 = 1'b0;
  endtask

  task automatic test_reset_midburst;
    int p;
    load32(16'd16, 32'h6666_0000); rx_ready32 = 1'b1;
    @(negedge clk_100_mhz);
    s_araddr = A_DATA; s_arlen = 8'd3; s_arvalid = 1'b1;
    @(negedge clk_100_mhz);
    s_arvalid = 1'b0; s_rready = 1'b1;
    @(negedge clk_100_mhz);
    rst = 1'b1;
    @(negedge clk_100_mhz); #1;
    p = int'(idx32);
    n_cmp++; if ({obs_rvalid, obs_rlast, obs_rresp, obs_arready} !== 5'b0 || obs_rdata !== 64'h0) begin n_bad++; $display("FAIL t6_outputs got=%b %h exp=00000 0", {obs_rvalid, obs_rlast, obs_rresp, obs_arready}, obs_rdata); end
    n_cmp++; if ({obs_read_en, obs_clear} !== 2'b00 || p !== 1) begin n_bad++; $display("FAIL t6_abort got=%b pops=%0d exp=00 pops=1", {obs_read_en, obs_clear}, p); end
    @(negedge clk_100_mhz);
    rst = 1'b0; s_rready = 1'b0;
    load32(16'd16, 32'h7777_0000);
    run_burst(A_DATA, 8'd3, '1);
    rx_ready32 = 1'b0;
    n_cmp++; if (nb !== 4 || b_data[0] !== 64'h7777_0000 || b_data[3] !== 64'h7777_0003) begin n_bad++; $display("FAIL t6_restart got=%0d %h %h exp=4 77770000 77770003", nb, b_data[0], b_data[3]); end
    n_cmp++; if (pops !== 4 || clears !== 1) begin n_bad++; $display("FAIL t6_pop_clear got=%0d/%0d exp=4/1", pops, clears); end
    run_burst(A_FRAMES, 8'd0, '1);
    n_cmp++; if (b_data[0] !== 64'd1) begin n_bad++; $display("FAIL t6_frames got=%h exp=1", b_data[0]); end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin mem32[i] = '0; mem64[i] = '0; end
    test_reset;
    test_single_frame;
    test_multi_burst;
    test_backpressure;
    test_unmapped;
    test_zero_len;
    test_width64;
    test_reset_midburst;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/eth_rx_axi_burst_reader.md
Name: eth_rx_axi_burst_reader

Overview:
Parametrised AXI4 read-channel front end for the Ethernet RX path. It replaces the single-beat RX read logic with full burst support at configurable data width. A frame is streamed from the first-word-fall-through (FWFT) RX FIFO of ethernet_module at one beat per cycle. Bursts are padded or split across frame boundaries, and status registers are readable with correct SLVERR on unmapped addresses. It sits between the AXI interconnect and the RX side of ethernet_module.

Parameters:
DATA_W, 32, AXI/FIFO data width; legal values 32 or 64.
ADDR_W, 16, width of s_araddr.
COUNT_W, 16, width of the frame byte count.
A_STATUS, 16'h0000, reg: bit0 = rx_ready, bit1 = frame_active.
A_COUNT, 16'h0004, reg: rx_byte_count, zero-extended.
A_PROTO, 16'h0008, reg: rx_protocol_type, zero-extended.
A_FRAMES, 16'h000C, reg: frames-consumed counter, 32 bit, wraps.
A_DATA, 16'h0010, RX data window.

Ports:
clk_100_mhz  in  1  sole clock.
rst  in  1  synchronous, active-high reset.
s_araddr  in  ADDR_W  read address.
s_arlen  in  8  beats minus 1.
s_arvalid  in  1  AR valid.
s_arready  out  1  AR ready.
s_rdata  out  DATA_W  read data.
s_rresp  out  2  00 = OKAY, 10 = SLVERR.
s_rlast  out  1  last beat of burst.
s_rvalid  out  1  R valid.
s_rready  in  1  R ready.
rx_ready  in  1  complete frame waiting in FIFO.
rx_byte_count  in  COUNT_W  byte length of waiting frame.
rx_protocol_type  in  16  EtherType of waiting frame.
rx_data  in  DATA_W  FWFT FIFO head word.
rx_read_en  out  1  pop FIFO head; 1-cycle pulse per word.
rx_clear  out  1  1-cycle pulse; frame fully consumed.

Behaviour:
- Reset values: s_arready=0, s_rvalid=0, s_rlast=0, s_rresp=00, s_rdata=0, rx_read_en=0, rx_clear=0. Frame state, remaining-word counter and frames counter all 0.
- Reset mid-burst aborts immediately: no further beats, and no rx_clear.
- FSM states: IDLE -> BURST -> (CLEAR) -> IDLE.
- IDLE:
  - s_arready=1.
  - On s_arvalid & s_arready: latch address and beats = s_arlen+1; go to BURST.
  - s_rvalid rises the next cycle (1-cycle AR-to-R latency).
- BURST:
  - s_rvalid held high until beats are exhausted.
  - On a stalled beat (s_rvalid & !s_rready), s_rdata, s_rresp and s_rlast hold stable.
  - A beat completes on s_rvalid & s_rready; s_rlast=1 exactly on beat number beats.
  - After the last handshake: return to IDLE, or go to CLEAR if a frame just ended.
- Register addresses (A_STATUS, A_COUNT, A_PROTO, A_FRAMES): every beat returns the register value sampled at that beat; s_rresp=OKAY.
- Unmapped address: all beats return s_rdata=0, s_rresp=SLVERR; the burst length is still honoured.
- A_DATA, frame start:
  - If frame_active=0 and rx_ready=1, set frame_active=1.
  - Set remaining = ceil(rx_byte_count / (DATA_W/8)); a byte count of 0 gives remaining=0 and ends the frame at once.
- A_DATA, per beat:
  - If remaining>0: s_rdata = rx_data (combinational from the FWFT head); rx_read_en = handshake; remaining decrements on handshake.
  - If remaining==0, or no frame is active: s_rdata=0 and no pop.
  - s_rresp=OKAY on all A_DATA beats.
  - Throughput is one beat per cycle; no bubbles while s_rready=1.
- Frame end:
  - When remaining goes 1->0, frame_active clears after that handshake.
  - Remaining beats in the burst are zero-padded.
  - rx_clear pulses for 1 cycle in CLEAR, entered after the final beat; the frames counter increments by 1, wrapping at 2^32.
- A frame longer than one burst: remaining and frame_active persist across bursts, and the next A_DATA burst continues from the next word.
- rx_ready deasserting while frame_active=1 is ignored until the frame ends.
- A new AR is accepted only in IDLE; s_arready=0 in BURST and CLEAR.

Test Plan:
1. DATA_W=32, frame of 10 bytes, AR A_DATA arlen=3, s_rready=1 -> 4 beats on consecutive cycles: words 0, 1, 2 then 0; rx_read_en pulses 3 times; rlast on beat 4; rx_clear 1 pulse after; A_FRAMES=1.
2. Frame of 24 bytes, two bursts of arlen=2 -> 3+3 words in FIFO order; rx_clear only after the second burst; STATUS bit1=1 between the bursts.
3. rready toggles 1,0,0,1 during a 4-beat A_DATA burst -> data stable while stalled; exactly one pop per handshake; no lost or duplicated words.
4. AR addr 16'h0020 arlen=1 -> 2 beats with rdata=0, rresp=10, rlast on beat 2; no rx_read_en.
5. DATA_W=64, byte count 9 -> remaining=2; A_COUNT reads 9; A_PROTO reads 16'h0800 when rx_protocol_type=0800.
6. Assert rst during beat 2 of 4 -> next cycle all outputs at reset values; no rx_clear; a subsequent A_DATA read with rx_ready=1 restarts the frame from the FIFO head.
